// File: rtl/thumb_uop_issuer.sv
// Thumb data-processing decoder/issuer: one ALU uop per instruction, two for BICS.
// Optional UOPSEQ_PERF_CNT_EN adds perf_uops / perf_illegal counters.
module thumb_uop_issuer #(
    parameter int unsigned IMM_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_uop,
    output logic [3:0]       out_lhs_sel,
    output logic [3:0]       out_rhs_sel,
    output logic [IMM_W-1:0] out_imm,
    output logic [3:0]       out_dst,
    output logic             out_wb_en,
    output logic             out_flags_en,
    output logic             illegal
`ifdef UOPSEQ_PERF_CNT_EN
    ,
    output logic [31:0]      perf_uops,
    output logic [15:0]      perf_illegal
`endif
);

    localparam logic [4:0] UOP_ADD = 5'd1;
    localparam logic [4:0] UOP_SUB = 5'd2;
    localparam logic [4:0] UOP_AND = 5'd3;
    localparam logic [4:0] UOP_XOR = 5'd4;
    localparam logic [4:0] UOP_CMP = 5'd5;
    localparam logic [4:0] UOP_LSL = 5'd6;
    localparam logic [4:0] UOP_LSR = 5'd7;
    localparam logic [4:0] UOP_MOV = 5'd8;
    localparam logic [3:0] SEL_TMP = 4'd8;
    localparam logic [3:0] SEL_IMM = 4'd15;

    typedef enum logic [1:0] {IDLE, HOLD, HOLD1} state_t;

    state_t           state;
    logic [2:0]       bics_rdn;
    logic             accept;
    logic             dec_legal;
    logic             dec_bics;
    logic [4:0]       dec_uop;
    logic [3:0]       dec_lhs;
    logic [3:0]       dec_rhs;
    logic [3:0]       dec_dst;
    logic [IMM_W-1:0] dec_imm;
    logic             dec_wb;
    logic             dec_fl;

    assign in_ready = (state == IDLE) || (state == HOLD && out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        dec_legal = 1'b0;
        dec_bics  = 1'b0;
        dec_uop   = '0;
        dec_lhs   = '0;
        dec_rhs   = '0;
        dec_dst   = '0;
        dec_imm   = '0;
        dec_wb    = 1'b0;
        dec_fl    = 1'b0;
        if (in_instr[15:13] == 3'b001) begin
            dec_legal = 1'b1;
            dec_lhs   = {1'b0, in_instr[10:8]};
            dec_rhs   = SEL_IMM;
            dec_dst   = {1'b0, in_instr[10:8]};
            dec_imm   = IMM_W'(in_instr[7:0]);
            dec_wb    = 1'b1;
            dec_fl    = 1'b1;
            case (in_instr[12:11])
                2'b00:   dec_uop = UOP_MOV;
                2'b01: begin
                    dec_uop = UOP_CMP;
                    dec_wb  = 1'b0;
                end
                2'b10:   dec_uop = UOP_ADD;
                default: dec_uop = UOP_SUB;
            endcase
        end else if (in_instr[15:10] == 6'b010000) begin
            dec_legal = 1'b1;
            dec_lhs   = {1'b0, in_instr[2:0]};
            dec_rhs   = {1'b0, in_instr[5:3]};
            dec_dst   = {1'b0, in_instr[2:0]};
            dec_wb    = 1'b1;
            dec_fl    = 1'b1;
            case (in_instr[9:6])
                4'b0000: dec_uop = UOP_AND;
                4'b0001: dec_uop = UOP_XOR;
                4'b0010: dec_uop = UOP_LSL;
                4'b0011: dec_uop = UOP_LSR;
                4'b1010: begin
                    dec_uop = UOP_CMP;
                    dec_wb  = 1'b0;
                end
                4'b1111: begin
                    dec_uop = UOP_XOR;
                    dec_lhs = {1'b0, in_instr[5:3]};
                    dec_rhs = SEL_IMM;
                    dec_imm = '1;
                end
                // BICS first half: TMP = ~Rm, no flag update until the AND
                4'b1110: begin
                    dec_bics = 1'b1;
                    dec_uop  = UOP_XOR;
                    dec_lhs  = {1'b0, in_instr[5:3]};
                    dec_rhs  = SEL_IMM;
                    dec_imm  = '1;
                    dec_dst  = SEL_TMP;
                    dec_fl   = 1'b0;
                end
                default: dec_legal = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bics_rdn     <= '0;
            out_valid    <= 1'b0;
            out_uop      <= '0;
            out_lhs_sel  <= '0;
            out_rhs_sel  <= '0;
            out_imm      <= '0;
            out_dst      <= '0;
            out_wb_en    <= 1'b0;
            out_flags_en <= 1'b0;
            illegal      <= 1'b0;
        end else begin
            illegal <= accept && !dec_legal;
            case (state)
                IDLE, HOLD: begin
                    if (state == IDLE || out_ready) begin
                        if (accept && dec_legal) begin
                            state        <= dec_bics ? HOLD1 : HOLD;
                            bics_rdn     <= in_instr[2:0];
                            out_valid    <= 1'b1;
                            out_uop      <= dec_uop;
                            out_lhs_sel  <= dec_lhs;
                            out_rhs_sel  <= dec_rhs;
                            out_imm      <= dec_imm;
                            out_dst      <= dec_dst;
                            out_wb_en    <= dec_wb;
                            out_flags_en <= dec_fl;
                        end else begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                        end
                    end
                end
                HOLD1: begin
                    if (out_ready) begin
                        state        <= HOLD;
                        out_uop      <= UOP_AND;
                        out_lhs_sel  <= {1'b0, bics_rdn};
                        out_rhs_sel  <= SEL_TMP;
                        out_imm      <= '0;
                        out_dst      <= {1'b0, bics_rdn};
                        out_wb_en    <= 1'b1;
                        out_flags_en <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef UOPSEQ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_uops    <= '0;
            perf_illegal <= '0;
        end else begin
            if (out_valid && out_ready)
                perf_uops <= perf_uops + 32'd1;
            if (accept && !dec_legal)
                perf_illegal <= perf_illegal + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_thumb_uop_issuer.sv
// Scoreboard bench for thumb_uop_issuer: driver pushes expected uops, negedge monitor pops/compares.
module tb_thumb_uop_issuer;

    typedef struct {
        logic [4:0]  uop;
        logic [3:0]  lhs;
        logic [3:0]  rhs;
        logic [31:0] imm;
        logic [3:0]  dst;
        logic        wb;
        logic        fl;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_instr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_uop;
    logic [3:0]  out_lhs_sel;
    logic [3:0]  out_rhs_sel;
    logic [31:0] out_imm;
    logic [3:0]  out_dst;
    logic        out_wb_en;
    logic        out_flags_en;
    logic        illegal;
`ifdef UOPSEQ_PERF_CNT_EN
    logic [31:0] perf_uops;
    logic [15:0] perf_illegal;
`endif

    thumb_uop_issuer #(.IMM_W(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_uop(out_uop), .out_lhs_sel(out_lhs_sel), .out_rhs_sel(out_rhs_sel),
        .out_imm(out_imm), .out_dst(out_dst), .out_wb_en(out_wb_en),
        .out_flags_en(out_flags_en), .illegal(illegal)
`ifdef UOPSEQ_PERF_CNT_EN
        , .perf_uops(perf_uops), .perf_illegal(perf_illegal)
`endif
    );

    always #5 clk = ~clk;

    int   nvec = 0;
    int   nfail = 0;
    int   cyc = 0;
    int   m_uops = 0;
    int   m_ill = 0;
    exp_t q[$];
    bit   ill_exp[int];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: instruction -> list of uops straight from the ISA description.
    function automatic int model(input logic [15:0] i, output exp_t a, output exp_t b);
        logic [3:0] rd, rm, rdn;
        a = '{uop: 0, lhs: 0, rhs: 0, imm: 0, dst: 0, wb: 0, fl: 0};
        b = a;
        rd  = {1'b0, i[10:8]};
        rm  = {1'b0, i[5:3]};
        rdn = {1'b0, i[2:0]};
        if (i[15:13] == 3'b001) begin
            a = '{uop: 0, lhs: rd, rhs: 15, imm: {24'd0, i[7:0]}, dst: rd, wb: 1, fl: 1};
            case (i[12:11])
                0: a.uop = 8;
                1: begin a.uop = 5; a.wb = 0; end
                2: a.uop = 1;
                3: a.uop = 2;
            endcase
            return 1;
        end
        if (i[15:10] != 6'b010000) return 0;
        a = '{uop: 0, lhs: rdn, rhs: rm, imm: 0, dst: rdn, wb: 1, fl: 1};
        case (i[9:6])
            4'd0:  a.uop = 3;
            4'd1:  a.uop = 4;
            4'd2:  a.uop = 6;
            4'd3:  a.uop = 7;
            4'd10: begin a.uop = 5; a.wb = 0; end
            4'd15: a = '{uop: 4, lhs: rm, rhs: 15, imm: 32'hFFFF_FFFF, dst: rdn, wb: 1, fl: 1};
            4'd14: begin
                a = '{uop: 4, lhs: rm, rhs: 15, imm: 32'hFFFF_FFFF, dst: 8, wb: 1, fl: 0};
                b = '{uop: 3, lhs: rdn, rhs: 8, imm: 0, dst: rdn, wb: 1, fl: 1};
                return 2;
            end
            default: return 0;
        endcase
        return 1;
    endfunction

    // Monitor: outstanding-uop count alone determines in_ready / out_valid.
    initial begin
        exp_t e;
        int   p;
        forever begin
            @(negedge clk);
            if (!rst) begin
                p = q.size();
                chk("in_ready", {31'd0, in_ready}, {31'd0, (p == 0) || (p == 1 && out_ready)});
                chk("out_valid", {31'd0, out_valid}, {31'd0, p > 0});
                if (out_valid && p > 0) begin
                    e = q[0];
                    chk("uop", {27'd0, out_uop}, {27'd0, e.uop});
                    chk("lhs", {28'd0, out_lhs_sel}, {28'd0, e.lhs});
                    chk("rhs", {28'd0, out_rhs_sel}, {28'd0, e.rhs});
                    if (e.rhs == 4'd15) chk("imm", out_imm, e.imm);
                    chk("dst", {28'd0, out_dst}, {28'd0, e.dst});
                    chk("wb_en", {31'd0, out_wb_en}, {31'd0, e.wb});
                    chk("flags_en", {31'd0, out_flags_en}, {31'd0, e.fl});
                    if (out_ready) begin
                        void'(q.pop_front());
                        m_uops++;
                    end
                end
                chk("illegal", {31'd0, illegal}, {31'd0, ill_exp.exists(cyc)});
                if (ill_exp.exists(cyc)) ill_exp.delete(cyc);
            end
        end
    end

    task automatic step(input logic v, input logic [15:0] instr, input logic ordy);
        exp_t a, b;
        int   n;
        @(posedge clk);
        #1;
        in_valid  = v;
        in_instr  = instr;
        out_ready = ordy;
        @(negedge clk);
        #1;
        if (in_valid && in_ready) begin
            n = model(instr, a, b);
            if (n == 0) begin
                ill_exp[cyc + 1] = 1'b1;
                m_ill++;
            end else begin
                q.push_back(a);
                if (n == 2) q.push_back(b);
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        q.delete();
        ill_exp.delete();
        m_uops = 0;
        m_ill  = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [15:0] ins;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_illegal", {31'd0, illegal}, 0);
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        chk("rst_fields", {out_uop, out_lhs_sel, out_rhs_sel, out_dst, out_wb_en, out_flags_en}, 0);
        chk("rst_imm", out_imm, 0);

        step(1, 16'h2212, 1);
        step(0, 16'h0000, 1);
        step(1, 16'h4019, 1);
        step(1, 16'h4059, 1);
        step(0, 16'h0000, 1);
        step(1, 16'h43A8, 1);
        step(0, 16'h0000, 1);
        step(0, 16'h0000, 1);
        step(1, 16'h2CFF, 0);
        repeat (3) step(0, 16'h0000, 0);
        step(0, 16'h0000, 1);
        step(1, 16'hDEAD, 1);
        step(0, 16'h0000, 1);
        step(0, 16'h0000, 1);
        // reset while BICS U1 is presented and stalled
        step(1, 16'h43A8, 0);
        step(0, 16'h0000, 0);
        do_reset();
        repeat (3) step(0, 16'h0000, 1);

        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 2))
                0:       ins = {3'b001, 13'($urandom)};
                1:       ins = {6'b010000, 10'($urandom)};
                default: ins = 16'($urandom);
            endcase
            if ($urandom_range(0, 299) == 0) do_reset();
            else step($urandom_range(0, 3) != 0, ins, $urandom_range(0, 3) != 0);
        end

        for (int i = 0; i < 20 && q.size() > 0; i++) step(0, 16'h0000, 1);
        chk("drain_empty", q.size(), 0);
        step(0, 16'h0000, 1);
        step(0, 16'h0000, 1);
`ifdef UOPSEQ_PERF_CNT_EN
        chk("perf_uops", perf_uops, m_uops);
        chk("perf_illegal", {16'd0, perf_illegal}, 32'(m_ill[15:0]));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/thumb_uop_issuer.md
Name: thumb_uop_issuer

Overview:
- Decodes 16-bit Thumb data-processing instructions into 5-bit ALU micro-ops plus operand/destination selects.
- Issues them to the ALU stage over a valid/ready handshake.
- Sits between instruction fetch and the ALU/register-file stage, as the producer end of the ALU uop interface.
- Single-uop instructions issue at one per cycle. BICS expands into two uops through an internal temp register.

Parameters:
- IMM_W, 32, width of the out_imm field; equals the ALU operand width.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  in_instr is valid
- in_ready  out  1  issuer accepts in_instr this cycle
- in_instr  in  16  Thumb instruction
- out_valid  out  1  uop fields valid
- out_ready  in  1  ALU stage accepts uop
- out_uop  out  5  1=ADD 2=SUB 3=AND 4=XOR 5=CMP 6=LSL 7=LSR 8=MOV; 0=NOP
- out_lhs_sel  out  4  0-7 = R0-R7, 8 = TMP, 15 = IMM
- out_rhs_sel  out  4  same encoding as out_lhs_sel
- out_imm  out  IMM_W  immediate operand, zero-extended
- out_dst  out  4  0-7 = R0-R7, 8 = TMP
- out_wb_en  out  1  write result to out_dst
- out_flags_en  out  1  update [Z,C,N,V]
- illegal  out  1  one-cycle pulse: an accepted instruction was unsupported

Behaviour:
- Reset:
  - state=IDLE.
  - out_valid=0, illegal=0.
  - All out_* fields = 0.
  - in_ready=1 on the cycle after reset deasserts.
  - rst mid-BICS drops the pending second uop; no partial issue.
- Format 3 (bits[15:13]=001; op=[12:11], Rd=[10:8], imm8=[7:0]):
  - Common: lhs=Rd, rhs=IMM, imm=zero-extended imm8, dst=Rd, flags_en=1.
  - op 00 MOVS → uop 8.
  - op 01 CMP → uop 5, wb_en=0.
  - op 10 ADDS → uop 1.
  - op 11 SUBS → uop 2.
- Format 4 (bits[15:10]=010000; op=[9:6], Rm=[5:3], Rdn=[2:0]):
  - Common: lhs=Rdn, rhs=Rm, dst=Rdn, wb_en=1, flags_en=1.
  - 0000 AND → uop 3.
  - 0001 EOR → uop 4.
  - 0010 LSL → uop 6.
  - 0011 LSR → uop 7.
  - 1010 CMP → uop 5, wb_en=0.
  - 1111 MVNS → uop 4, lhs=Rm, rhs=IMM, imm=0xFFFFFFFF.
  - 1110 BICS → two uops:
    - U1: XOR, lhs=Rm, rhs=IMM, imm=0xFFFFFFFF, dst=TMP, wb_en=1, flags_en=0.
    - U2: AND, lhs=Rdn, rhs=TMP, dst=Rdn, wb_en=1, flags_en=1.
- Any other encoding:
  - Accepted (in_ready honoured).
  - Nothing issued.
  - illegal=1 the cycle after acceptance.
- FSM states:
  - IDLE: output register empty.
  - HOLD: single uop or U2 pending.
  - HOLD1: BICS U1 pending.
- Transitions:
  - IDLE + accepted single-uop instruction → HOLD.
  - IDLE + accepted BICS → HOLD1.
  - HOLD + out_ready → IDLE, or straight to HOLD/HOLD1 if a new instruction is accepted the same cycle (back-to-back).
  - HOLD1 + out_ready → HOLD, output loaded with U2.
- in_ready = (state==IDLE) | (state==HOLD & out_ready).
  - in_ready=0 in HOLD1.
  - in_ready=0 in HOLD without out_ready.
- Latency: instruction accepted in cycle N → out_valid=1 in N+1.
- Output stability: while out_valid=1 & out_ready=0, all out_* fields hold stable (no change until handshake).
- Illegal accepted while the output drains same cycle: state → IDLE, out_valid=0 next cycle.
- in_valid=0: no state change except draining.

Optional Feature:
- Macro: UOPSEQ_PERF_CNT_EN.
- Defined:
  - Adds output perf_uops (32-bit): count of completed out handshakes.
  - Adds output perf_illegal (16-bit): count of illegal instructions.
  - Both reset to 0, wrap on overflow, and increment in the cycle after the event.
- Undefined: neither port nor counter logic exists; behaviour otherwise identical.

Test Plan:
- Reset, then MOVS R2,#0x12 (0x2212) with out_ready=1 → next cycle:
  - out_valid=1, uop=8, lhs=2, rhs=15, imm=0x12, dst=2, wb_en=1, flags_en=1.
- Back-to-back AND R1,R3 (0x4019) then EOR R1,R3 (0x4059), out_ready=1 → uops 3 then 4 on consecutive cycles; in_ready stays 1.
- BICS R0,R5 (0x43A8) with out_ready=1:
  - U1: uop 4, lhs=5, imm=0xFFFFFFFF, dst=8, flags_en=0.
  - U2: uop 3, lhs=0, rhs=8, dst=0, flags_en=1.
  - in_ready=0 during U1.
- CMP R4,#0xFF (0x2CFF) with out_ready=0 for 3 cycles:
  - uop 5, wb_en=0.
  - Fields stable, in_ready=0 until out_ready=1.
- Unsupported 0xDEAD accepted → illegal pulses 1 cycle, out_valid stays 0; with UOPSEQ_PERF_CNT_EN, perf_illegal=1.
- rst asserted during BICS U1 → next cycle out_valid=0, state IDLE; U2 never issues.
